// File: rtl/hazard_pkg.sv
// Shared definitions for the RV32I pipeline hazard controller:
// forwarding select encodings and the watchdog FSM state encoding.
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;  // operand from register file
    localparam logic [1:0] FWD_WB  = 2'b01;  // operand from writeback result
    localparam logic [1:0] FWD_MEM = 2'b10;  // operand from memory-stage ALU result

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_WAIT  = 2'b01,
        ST_ERROR = 2'b10
    } state_t;

endpackage

// File: rtl/hazard_fwd_sel.sv
// EX-stage forwarding select for one source operand.
// The memory-stage producer is newer than the writeback one, so it wins.
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] rs_i,
    input  logic [REG_ADDR_W-1:0] rd_m_i,
    input  logic [REG_ADDR_W-1:0] rd_w_i,
    input  logic                  reg_write_m_i,
    input  logic                  reg_write_w_i,
    output logic [1:0]            sel_o
);

    // Pick the youngest in-flight producer of rs_i; x0 is never forwarded.
    always_comb begin
        sel_o = FWD_RF;
        if (reg_write_m_i && (rd_m_i != '0) && (rd_m_i == rs_i)) begin
            sel_o = FWD_MEM;
        end else if (reg_write_w_i && (rd_w_i != '0) && (rd_w_i == rs_i)) begin
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32I core: forwarding selects,
// load-use stall, taken-branch flush, memory-busy freeze and a sticky
// memory-wait watchdog. Optional perf counters are built when the macro
// HAZARD_PERF_EN is defined; otherwise StallCnt/FlushCnt are tied to zero.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int TIMEOUT    = 16,
    parameter int CNT_W      = $clog2(TIMEOUT + 1),
    parameter int PERF_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] Rs1D,
    input  logic [REG_ADDR_W-1:0] Rs2D,
    input  logic [REG_ADDR_W-1:0] Rs1E,
    input  logic [REG_ADDR_W-1:0] Rs2E,
    input  logic [REG_ADDR_W-1:0] RdE,
    input  logic [REG_ADDR_W-1:0] RdM,
    input  logic [REG_ADDR_W-1:0] RdW,
    input  logic                  ResultSrcE0,
    input  logic                  RegWriteM,
    input  logic                  RegWriteW,
    input  logic                  PCSrcE,
    input  logic                  MemBusyM,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  StallE,
    output logic                  StallM,
    output logic                  FlushD,
    output logic                  FlushE,
    output logic [1:0]            ForwardAE,
    output logic [1:0]            ForwardBE,
    output logic                  MemTimeout,
    output logic [PERF_W-1:0]     StallCnt,
    output logic [PERF_W-1:0]     FlushCnt
);

    state_t           state_q;
    logic [CNT_W-1:0] wcnt_q;
    logic             timeout_q;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             load_use;
    logic             in_error;

    hazard_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
        .rs_i          (Rs1E),
        .rd_m_i        (RdM),
        .rd_w_i        (RdW),
        .reg_write_m_i (RegWriteM),
        .reg_write_w_i (RegWriteW),
        .sel_o         (fwd_a)
    );

    hazard_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
        .rs_i          (Rs2E),
        .rd_m_i        (RdM),
        .rd_w_i        (RdW),
        .reg_write_m_i (RegWriteM),
        .reg_write_w_i (RegWriteW),
        .sel_o         (fwd_b)
    );

    assign load_use   = ResultSrcE0 && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
    assign in_error   = (state_q == ST_ERROR);
    assign MemTimeout = timeout_q;

    // Watchdog FSM: counts consecutive busy cycles, ERROR is absorbing until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            wcnt_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (MemBusyM) begin
                        state_q <= ST_WAIT;
                        wcnt_q  <= CNT_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (!MemBusyM) begin
                        state_q <= ST_RUN;
                        wcnt_q  <= '0;
                    end else if (wcnt_q == CNT_W'(TIMEOUT - 1)) begin
                        state_q   <= ST_ERROR;
                        timeout_q <= 1'b1;
                    end else begin
                        wcnt_q <= wcnt_q + CNT_W'(1);
                    end
                end
                ST_ERROR: begin
                    state_q   <= ST_ERROR;
                    timeout_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_RUN;
                    wcnt_q  <= '0;
                end
            endcase
        end
    end

    // Stall/flush/forward arbitration: reset > error > freeze > branch > load-use.
    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        ForwardAE = fwd_a;
        ForwardBE = fwd_b;
        if (rst) begin
            FlushD    = 1'b1;
            FlushE    = 1'b1;
            ForwardAE = FWD_RF;
            ForwardBE = FWD_RF;
        end else if (in_error) begin
            StallF    = 1'b1;
            StallD    = 1'b1;
            StallE    = 1'b1;
            StallM    = 1'b1;
            ForwardAE = FWD_RF;
            ForwardBE = FWD_RF;
        end else if (MemBusyM) begin
            // Branch and load-use inputs sit in frozen regs and resolve after the freeze.
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
        end else if (PCSrcE) begin
            // The decode instruction is discarded, so a same-cycle load-use is moot.
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (load_use) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] stall_cnt_q;
    logic [PERF_W-1:0] flush_cnt_q;
    logic              stall_any;
    logic              flush_any;

    assign stall_any = (StallF || StallD || StallE || StallM) && !in_error;
    assign flush_any = (FlushD || FlushE) && !rst;
    assign StallCnt  = stall_cnt_q;
    assign FlushCnt  = flush_cnt_q;

    // Saturating perf counters for stall and flush cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_any && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + PERF_W'(1);
            end
            if (flush_any && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + PERF_W'(1);
            end
        end
    end
`else
    assign StallCnt = '0;
    assign FlushCnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl (TIMEOUT=16). Perf-counter
// expectations follow the HAZARD_PERF_EN macro.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       ResultSrcE0, RegWriteM, RegWriteW, PCSrcE, MemBusyM;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE, MemTimeout;
    logic [1:0] ForwardAE, ForwardBE;
    logic [31:0] StallCnt, FlushCnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_ADDR_W(5), .TIMEOUT(16), .PERF_W(32)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .ResultSrcE0(ResultSrcE0), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .PCSrcE(PCSrcE), .MemBusyM(MemBusyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .MemTimeout(MemTimeout), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Packed control view: {StallF,StallD,StallE,StallM,FlushD,FlushE}
    function automatic logic [31:0] ctl();
        return {26'd0, StallF, StallD, StallE, StallM, FlushD, FlushE};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        ResultSrcE0 = 0; RegWriteM = 0; RegWriteW = 0; PCSrcE = 0; MemBusyM = 0;
        tick();
        tick();
        #2;
        chk("rst_ctl", ctl(), 32'b000011);
        chk("rst_timeout", MemTimeout, 0);
        chk("rst_stallcnt", StallCnt, 0);
        rst = 1'b0;
        #2;
        chk("run_idle_ctl", ctl(), 32'b000000);

        // Forwarding priority
        RegWriteM = 1; RdM = 5; RegWriteW = 1; RdW = 5; Rs1E = 5; Rs2E = 7;
        #2;
        chk("fwdA_mem", ForwardAE, 2'b10);
        chk("fwdB_none", ForwardBE, 2'b00);
        RdM = 0;
        #2;
        chk("fwdA_wb", ForwardAE, 2'b01);
        RdW = 0;
        #2;
        chk("fwdA_rf", ForwardAE, 2'b00);
        RegWriteM = 0; RdM = 5; RdW = 5; Rs2E = 5;
        #2;
        chk("fwdB_wb_regwritem_off", ForwardBE, 2'b01);
        chk("fwd_no_stall", ctl(), 32'b000000);
        RegWriteM = 0; RegWriteW = 0; RdM = 0; RdW = 0; Rs1E = 0; Rs2E = 0;
        tick();

        // Load-use: one cycle, then the load has advanced
        ResultSrcE0 = 1; RdE = 3; Rs2D = 3;
        #2;
        chk("lu_ctl", ctl(), 32'b110001);
        tick();
        ResultSrcE0 = 0; RdE = 0;
        #2;
        chk("lu_after_ctl", ctl(), 32'b000000);
        ResultSrcE0 = 1; RdE = 0; Rs2D = 0;
        #2;
        chk("lu_x0_ctl", ctl(), 32'b000000);
        tick();

        // Branch beats load-use
        ResultSrcE0 = 1; RdE = 3; Rs1D = 3; PCSrcE = 1;
        #2;
        chk("br_lu_ctl", ctl(), 32'b000011);
        tick();
        ResultSrcE0 = 0; RdE = 0; Rs1D = 0; PCSrcE = 0;
        #2;
`ifdef HAZARD_PERF_EN
        chk("perf_stallcnt", StallCnt, 1);
        chk("perf_flushcnt", FlushCnt, 2);
`else
        chk("perf_stallcnt", StallCnt, 0);
        chk("perf_flushcnt", FlushCnt, 0);
`endif

        // Freeze defers a pending branch
        PCSrcE = 1; MemBusyM = 1;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk($sformatf("freeze_ctl_%0d", i), ctl(), 32'b111100);
            tick();
        end
        MemBusyM = 0;
        #2;
        chk("post_freeze_ctl", ctl(), 32'b000011);
        chk("post_freeze_timeout", MemTimeout, 0);
        tick();
        PCSrcE = 0;
        #2;
        chk("post_freeze_idle", ctl(), 32'b000000);

        // Watchdog: 16 busy cycles then sticky error
        MemBusyM = 1;
        for (int i = 0; i < 16; i++) begin
            #2;
            chk($sformatf("wd_busy_timeout_%0d", i), MemTimeout, 0);
            tick();
        end
        #2;
        chk("wd_timeout_set", MemTimeout, 1);
        MemBusyM = 0; RegWriteM = 1; RdM = 5; Rs1E = 5;
        #2;
        chk("err_ctl", ctl(), 32'b111100);
        chk("err_fwdA", ForwardAE, 2'b00);
        tick();
        #2;
        chk("err_timeout_held", MemTimeout, 1);
        rst = 1'b1;
        #2;
        chk("err_rst_ctl", ctl(), 32'b000011);
        tick();
        rst = 1'b0;
        #2;
        chk("rst_clears_timeout", MemTimeout, 0);
        chk("rst_run_ctl", ctl(), 32'b000000);
        chk("rst_run_fwdA", ForwardAE, 2'b10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
